// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg
// Shared definitions for the SPI NOR-flash target emulator.
//   - Opcode constants for the supported commands.
//   - FSM state encoding.
//   - op_supported(): tells the command decoder whether an opcode has a handler
//     in this build.
// Build option: SPI_TARGET_FAST_READ_EN adds FAST_READ (0x0B) to the
// supported set.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDID      = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        IGNORE
    } state_t;

    function automatic logic op_supported(input logic [7:0] op);
`ifdef SPI_TARGET_FAST_READ_EN
        return (op == OP_READ) || (op == OP_RDID) || (op == OP_FAST_READ);
`else
        return (op == OP_READ) || (op == OP_RDID);
`endif
    endfunction

endpackage

// File: rtl/spi_flash_target_if.sv
// spi_flash_target_if
// Bundles the SPI pins and the byte-wide memory read port of the flash target.
//   sclk, cs_n, mosi : SPI host -> target (asynchronous to clk)
//   miso, miso_oe    : target -> SPI host
//   mem_rd, mem_addr : target -> memory, one-cycle read strobe plus byte address
//   mem_rdata        : memory -> target, valid one clk after mem_rd
// Modports:
//   slave  : the flash target itself
//   master : the environment around it (SPI host plus backing memory)
interface spi_flash_target_if #(
    parameter int ADDR_W = 24
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    modport slave (
        input  sclk, cs_n, mosi, mem_rdata,
        output miso, miso_oe, mem_rd, mem_addr
    );

    modport master (
        output sclk, cs_n, mosi, mem_rdata,
        input  miso, miso_oe, mem_rd, mem_addr
    );
endinterface

// File: rtl/spi_in_sync.sv
// spi_in_sync
// Brings the asynchronous SPI pins into the clk domain and derives edge events.
// Ports:
//   clk, n_rst          : system clock, synchronous active-low reset
//   sclk, cs_n, mosi    : raw asynchronous SPI inputs
//   sclk_rise/sclk_fall : one-cycle pulses for sclk edges
//   cs_fall/cs_rise     : one-cycle pulses for chip-select edges
//   cs_n_lvl, mosi_lvl  : synchronized levels, aligned with the edge pulses
// Parameter SYNC_STAGES (>= 2) sets the synchronizer depth.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_n_lvl,
    output logic mosi_lvl
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sclk_lvl;

    // The *_lvl registers trail the synchronizer output by one clk, and the
    // edge pulses are registered from the same comparison, so a pulse and the
    // new level appear in the same cycle. mosi is delayed identically so the
    // bit seen with sclk_rise is the one present when sclk went high.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sclk_ff   <= '0;
            cs_ff     <= '1;
            mosi_ff   <= '0;
            sclk_lvl  <= 1'b0;
            cs_n_lvl  <= 1'b1;
            mosi_lvl  <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            cs_ff     <= {cs_ff[SYNC_STAGES-2:0], cs_n};
            mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], mosi};
            sclk_lvl  <= sclk_ff[SYNC_STAGES-1];
            cs_n_lvl  <= cs_ff[SYNC_STAGES-1];
            mosi_lvl  <= mosi_ff[SYNC_STAGES-1];
            sclk_rise <=  sclk_ff[SYNC_STAGES-1] & ~sclk_lvl;
            sclk_fall <= ~sclk_ff[SYNC_STAGES-1] &  sclk_lvl;
            cs_fall   <= ~cs_ff[SYNC_STAGES-1]   &  cs_n_lvl;
            cs_rise   <=  cs_ff[SYNC_STAGES-1]   & ~cs_n_lvl;
        end
    end

endmodule

// File: rtl/spi_flash_target.sv
// spi_flash_target
// SPI mode-0 target that answers like a serial NOR flash, serving reads out of
// an FPGA-side byte memory. Everything runs on clk; the SPI pins are
// oversampled through spi_in_sync.
// Ports:
//   clk     : system clock
//   n_rst   : synchronous active-low reset
//   bus     : spi_flash_target_if.slave (SPI pins + memory read port)
//   busy    : high while cs_n is sampled low
//   cmd_err : one-cycle pulse when an unsupported opcode completes
// Commands: READ 0x03, RDID 0x9F; FAST_READ 0x0B (with one dummy byte) only
// when SPI_TARGET_FAST_READ_EN is defined.
module spi_flash_target
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    spi_flash_target_if.slave   bus,
    output logic                busy,
    output logic                cmd_err
);

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_lvl, mosi_lvl;

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .n_rst    (n_rst),
        .sclk     (bus.sclk),
        .cs_n     (bus.cs_n),
        .mosi     (bus.mosi),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .cs_n_lvl (cs_n_lvl),
        .mosi_lvl (mosi_lvl)
    );

    state_t            state, state_nxt;
    logic [4:0]        bit_cnt;
    logic [22:0]       in_sr;
    logic [23:0]       out_sr;
    logic              rd_pending;
    logic              oe_r;
    logic              miso_r;
    logic              mem_rd_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              deselect;
    logic [7:0]        opcode_now;
    logic [23:0]       addr_now;
    logic              cmd_done, addr_done, byte_done;
`ifdef SPI_TARGET_FAST_READ_EN
    logic              fast_r;
    logic              dummy_done;
`endif

    // Deselect dominates every other event, including an sclk edge in the
    // same cycle.
    assign deselect   = cs_n_lvl | cs_rise;
    // Opcode/address as they stand once the current rising-edge bit is added.
    assign opcode_now = {in_sr[6:0], mosi_lvl};
    assign addr_now   = {in_sr, mosi_lvl};
    assign cmd_done   = (state == CMD)  && sclk_rise && (bit_cnt == 5'd7);
    assign addr_done  = (state == ADDR) && sclk_rise && (bit_cnt == 5'd23);
    assign byte_done  = (state == DATA) && sclk_rise && (bit_cnt == 5'd7);
`ifdef SPI_TARGET_FAST_READ_EN
    assign dummy_done = (state == DUMMY) && sclk_rise && (bit_cnt == 5'd7);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (deselect) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (cs_fall) state_nxt = CMD;
                CMD: begin
                    if (cmd_done) begin
                        if (opcode_now == OP_READ) begin
                            state_nxt = ADDR;
                        end else if (opcode_now == OP_RDID) begin
                            state_nxt = ID;
`ifdef SPI_TARGET_FAST_READ_EN
                        end else if (opcode_now == OP_FAST_READ) begin
                            state_nxt = ADDR;
`endif
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (addr_done) begin
`ifdef SPI_TARGET_FAST_READ_EN
                        state_nxt = fast_r ? DUMMY : DATA;
`else
                        state_nxt = DATA;
`endif
                    end
                end
`ifdef SPI_TARGET_FAST_READ_EN
                DUMMY: if (dummy_done) state_nxt = DATA;
`endif
                DATA, ID, IGNORE: state_nxt = state;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs. miso_oe falls in the very cycle the deselect is seen.
    always_comb begin
        busy    = ~cs_n_lvl;
        bus.miso_oe = oe_r & ~deselect & ((state == DATA) || (state == ID));
    end

    assign bus.miso     = miso_r;
    assign bus.mem_rd   = mem_rd_r;
    assign bus.mem_addr = mem_addr_r;

    // Datapath. out_sr is the single transmit register for both DATA and ID:
    // a fetched byte lands in its top 8 bits and ones shift in from below, so
    // RDID naturally returns 0xFF after the 24 ID bits.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bit_cnt    <= '0;
            in_sr      <= '0;
            out_sr     <= '1;
            rd_pending <= 1'b0;
            oe_r       <= 1'b0;
            miso_r     <= 1'b1;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= '0;
            cmd_err    <= 1'b0;
`ifdef SPI_TARGET_FAST_READ_EN
            fast_r     <= 1'b0;
`endif
        end else begin
            mem_rd_r   <= 1'b0;
            cmd_err    <= 1'b0;
            rd_pending <= mem_rd_r;
            if (deselect) begin
                // A fetch still in flight is dropped here; its data never loads.
                bit_cnt    <= '0;
                in_sr      <= '0;
                out_sr     <= '1;
                rd_pending <= 1'b0;
                oe_r       <= 1'b0;
                miso_r     <= 1'b1;
            end else begin
                if (rd_pending) begin
                    out_sr <= {bus.mem_rdata, 16'hFFFF};
                end
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        in_sr   <= '0;
                        oe_r    <= 1'b0;
                        miso_r  <= 1'b1;
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            in_sr   <= {in_sr[21:0], mosi_lvl};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (cmd_done) begin
                                bit_cnt <= '0;
                                cmd_err <= ~op_supported(opcode_now);
                                if (opcode_now == OP_RDID) begin
                                    out_sr <= JEDEC_ID;
                                end
`ifdef SPI_TARGET_FAST_READ_EN
                                fast_r <= (opcode_now == OP_FAST_READ);
`endif
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            in_sr   <= {in_sr[21:0], mosi_lvl};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (addr_done) begin
                                bit_cnt    <= '0;
                                mem_rd_r   <= 1'b1;
                                mem_addr_r <= addr_now[ADDR_W-1:0];
                            end
                        end
                    end
`ifdef SPI_TARGET_FAST_READ_EN
                    DUMMY: begin
                        if (sclk_rise) begin
                            bit_cnt <= dummy_done ? 5'd0 : bit_cnt + 5'd1;
                        end
                    end
`endif
                    DATA: begin
                        // Each byte boundary requests the next byte; it is in
                        // out_sr two clks later, well before the next fall.
                        if (sclk_rise) begin
                            bit_cnt <= byte_done ? 5'd0 : bit_cnt + 5'd1;
                            if (byte_done) begin
                                mem_rd_r   <= 1'b1;
                                mem_addr_r <= mem_addr_r + ADDR_W'(1);
                            end
                        end
                        if (sclk_fall) begin
                            miso_r <= out_sr[23];
                            out_sr <= {out_sr[22:0], 1'b1};
                            oe_r   <= 1'b1;
                        end
                    end
                    ID: begin
                        if (sclk_fall) begin
                            miso_r <= out_sr[23];
                            out_sr <= {out_sr[22:0], 1'b1};
                            oe_r   <= 1'b1;
                        end
                    end
                    default: begin
                        oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_target.sv
// tb_spi_flash_target
// Self-checking bench for spi_flash_target. Acts as SPI host (mode 0, half
// period of HALF clks) and as the backing memory, whose content is
// addr[7:0] ^ addr[23:16] ^ mem_key. Expected data is derived from that rule
// and from the command set; FAST_READ checks follow SPI_TARGET_FAST_READ_EN.
module tb_spi_flash_target;
    import spi_flash_pkg::*;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic n_rst;
    logic busy, cmd_err;

    spi_flash_target_if #(.ADDR_W(24)) bus();

    spi_flash_target #(
        .ADDR_W(24), .JEDEC_ID(24'hEF4018), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus.slave), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mem_key;
    logic [23:0] rd_q[$];
    int          cmd_err_cnt = 0;
    int          oe_cnt = 0;
    logic [7:0]  rx_buf[16];

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[23:16] ^ mem_key;
    endfunction

    // Backing memory: data valid the clk after the strobe.
    always @(posedge clk) begin
        if (!n_rst) bus.mem_rdata <= 8'h00;
        else if (bus.mem_rd) bus.mem_rdata <= mem_byte(bus.mem_addr);
    end

    // Event monitors; tests work from snapshots of these.
    always @(negedge clk) begin
        if (bus.mem_rd === 1'b1) rd_q.push_back(bus.mem_addr);
        if (cmd_err === 1'b1) cmd_err_cnt++;
        if (bus.miso_oe === 1'b1) oe_cnt++;
    end

    initial begin
        #1600000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.mosi = tx[i];
            clk_wait(HALF);
            bus.sclk = 1'b1;
            rx[i] = bus.miso;
            clk_wait(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        bus.cs_n = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic spi_end();
        clk_wait(HALF);
        bus.cs_n = 1'b1;
        clk_wait(3 * HALF);
    endtask

    // Stimulus only: opcode, 3 address bytes, optional dummy byte, nbytes
    // data bytes captured into rx_buf.
    task automatic run_read(input logic [7:0] op, input logic [23:0] addr,
                            input int nbytes, input bit dummy);
        logic [7:0] junk;
        spi_begin();
        spi_bits(op, 8, junk);
        spi_bits(addr[23:16], 8, junk);
        spi_bits(addr[15:8], 8, junk);
        spi_bits(addr[7:0], 8, junk);
        if (dummy) spi_bits(8'($urandom), 8, junk);
        for (int k = 0; k < nbytes; k++) spi_bits(8'($urandom), 8, rx_buf[k]);
        spi_end();
    endtask

    task automatic test_reset();
        logic [7:0] junk;
        clk_wait(5);
        total += 7;
        if (bus.miso !== 1'b1)      begin bad++; $display("[TB] FAIL reset_miso got=%b exp=1", bus.miso); end
        if (bus.miso_oe !== 1'b0)   begin bad++; $display("[TB] FAIL reset_oe got=%b exp=0", bus.miso_oe); end
        if (bus.mem_rd !== 1'b0)    begin bad++; $display("[TB] FAIL reset_mem_rd got=%b exp=0", bus.mem_rd); end
        if (bus.mem_addr !== 24'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        if (busy !== 1'b0)          begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        if (cmd_err !== 1'b0)       begin bad++; $display("[TB] FAIL reset_cmd_err got=%b exp=0", cmd_err); end
        if (dut.state !== IDLE)     begin bad++; $display("[TB] FAIL reset_state got=%0d exp=IDLE", dut.state); end
        n_rst = 1'b1;
        clk_wait(2 * HALF);
        // Reset in the middle of a READ data phase.
        spi_begin();
        spi_bits(OP_READ, 8, junk);
        spi_bits(8'h12, 8, junk);
        spi_bits(8'h34, 8, junk);
        spi_bits(8'h56, 8, junk);
        spi_bits(8'h00, 3, junk);
        n_rst = 1'b0;
        bus.cs_n = 1'b1;
        clk_wait(3);
        total += 7;
        if (bus.miso !== 1'b1)      begin bad++; $display("[TB] FAIL midreset_miso got=%b exp=1", bus.miso); end
        if (bus.miso_oe !== 1'b0)   begin bad++; $display("[TB] FAIL midreset_oe got=%b exp=0", bus.miso_oe); end
        if (bus.mem_rd !== 1'b0)    begin bad++; $display("[TB] FAIL midreset_mem_rd got=%b exp=0", bus.mem_rd); end
        if (bus.mem_addr !== 24'h0) begin bad++; $display("[TB] FAIL midreset_mem_addr got=%h exp=0", bus.mem_addr); end
        if (busy !== 1'b0)          begin bad++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
        if (cmd_err !== 1'b0)       begin bad++; $display("[TB] FAIL midreset_cmd_err got=%b exp=0", cmd_err); end
        if (dut.state !== IDLE)     begin bad++; $display("[TB] FAIL midreset_state got=%0d exp=IDLE", dut.state); end
        n_rst = 1'b1;
        clk_wait(4 * HALF);
    endtask

    task automatic test_read_basic();
        logic [7:0]  exp_d[4];
        logic [23:0] got_a;
        int          q0, e0;
        exp_d = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        mem_key = 8'hA5;
        q0 = rd_q.size();
        e0 = cmd_err_cnt;
        run_read(OP_READ, 24'h000010, 4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rx_buf[k] !== exp_d[k]) begin bad++; $display("[TB] FAIL read_byte%0d got=%h exp=%h", k, rx_buf[k], exp_d[k]); end
        end
        total++;
        if (rd_q.size() - q0 !== 5) begin bad++; $display("[TB] FAIL read_fetch_count got=%0d exp=5", rd_q.size() - q0); end
        for (int k = 0; k < 5; k++) begin
            got_a = (q0 + k < rd_q.size()) ? rd_q[q0 + k] : 24'hxxxxxx;
            total++;
            if (got_a !== 24'h10 + 24'(k)) begin bad++; $display("[TB] FAIL read_addr%0d got=%h exp=%h", k, got_a, 24'h10 + 24'(k)); end
        end
        total++;
        if (cmd_err_cnt != e0) begin bad++; $display("[TB] FAIL read_cmd_err got=%0d exp=0", cmd_err_cnt - e0); end
    endtask

    task automatic test_read_random();
        logic [23:0] addr, got_a, exp_a;
        int          n, q0;
        for (int it = 0; it < 4; it++) begin
            addr = 24'($urandom);
            mem_key = 8'($urandom);
            n = $urandom_range(1, 6);
            q0 = rd_q.size();
            run_read(OP_READ, addr, n, 1'b0);
            for (int k = 0; k < n; k++) begin
                total++;
                if (rx_buf[k] !== mem_byte(addr + 24'(k))) begin
                    bad++; $display("[TB] FAIL rand_read_byte%0d got=%h exp=%h", k, rx_buf[k], mem_byte(addr + 24'(k)));
                end
            end
            for (int k = 0; k <= n; k++) begin
                got_a = (q0 + k < rd_q.size()) ? rd_q[q0 + k] : 24'hxxxxxx;
                exp_a = addr + 24'(k);
                total++;
                if (got_a !== exp_a) begin bad++; $display("[TB] FAIL rand_read_addr%0d got=%h exp=%h", k, got_a, exp_a); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [23:0] exp_a[3];
        logic [23:0] got_a;
        int          q0;
        exp_a = '{24'hFFFFFF, 24'h000000, 24'h000001};
        mem_key = 8'h3C;
        q0 = rd_q.size();
        run_read(OP_READ, 24'hFFFFFF, 2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            got_a = (q0 + k < rd_q.size()) ? rd_q[q0 + k] : 24'hxxxxxx;
            total++;
            if (got_a !== exp_a[k]) begin bad++; $display("[TB] FAIL wrap_addr%0d got=%h exp=%h", k, got_a, exp_a[k]); end
        end
        total += 2;
        if (rx_buf[0] !== mem_byte(24'hFFFFFF)) begin bad++; $display("[TB] FAIL wrap_byte0 got=%h exp=%h", rx_buf[0], mem_byte(24'hFFFFFF)); end
        if (rx_buf[1] !== mem_byte(24'h000000)) begin bad++; $display("[TB] FAIL wrap_byte1 got=%h exp=%h", rx_buf[1], mem_byte(24'h000000)); end
    endtask

    task automatic test_rdid();
        logic [7:0] exp_d[4];
        logic [7:0] junk;
        int         e0, q0;
        exp_d = '{8'hEF, 8'h40, 8'h18, 8'hFF};
        e0 = cmd_err_cnt;
        q0 = rd_q.size();
        spi_begin();
        spi_bits(OP_RDID, 8, junk);
        for (int k = 0; k < 4; k++) spi_bits(8'($urandom), 8, rx_buf[k]);
        spi_end();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rx_buf[k] !== exp_d[k]) begin bad++; $display("[TB] FAIL rdid_byte%0d got=%h exp=%h", k, rx_buf[k], exp_d[k]); end
        end
        total += 2;
        if (cmd_err_cnt != e0) begin bad++; $display("[TB] FAIL rdid_cmd_err got=%0d exp=0", cmd_err_cnt - e0); end
        if (rd_q.size() != q0) begin bad++; $display("[TB] FAIL rdid_mem_rd got=%0d exp=0", rd_q.size() - q0); end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] op, junk;
        int         e0, o0;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) op = 8'h5A;
            else begin
                do op = 8'($urandom);
                while (op == OP_READ || op == OP_RDID || op == OP_FAST_READ);
            end
            e0 = cmd_err_cnt;
            o0 = oe_cnt;
            spi_begin();
            spi_bits(op, 8, junk);
            for (int k = 0; k < 3; k++) spi_bits(8'($urandom), 8, junk);
            spi_end();
            total += 2;
            if (cmd_err_cnt - e0 != 1) begin bad++; $display("[TB] FAIL bad_op_%h_cmd_err got=%0d exp=1", op, cmd_err_cnt - e0); end
            if (oe_cnt != o0)          begin bad++; $display("[TB] FAIL bad_op_%h_oe got=%0d exp=0", op, oe_cnt - o0); end
        end
    endtask

    task automatic test_abort();
        logic [23:0] addr;
        logic [7:0]  part, junk;
        int          waited;
        addr = 24'($urandom);
        mem_key = 8'($urandom);
        spi_begin();
        spi_bits(OP_READ, 8, junk);
        spi_bits(addr[23:16], 8, junk);
        spi_bits(addr[15:8], 8, junk);
        spi_bits(addr[7:0], 8, junk);
        spi_bits(8'h00, 3, part);
        total += 2;
        if (part[7:5] !== mem_byte(addr) >> 5) begin bad++; $display("[TB] FAIL abort_bits got=%b exp=%b", part[7:5], mem_byte(addr) >> 5); end
        if (bus.miso_oe !== 1'b1) begin bad++; $display("[TB] FAIL abort_oe_before got=%b exp=1", bus.miso_oe); end
        clk_wait(HALF);
        bus.cs_n = 1'b1;
        waited = 0;
        while (busy !== 1'b0 && waited < 12) begin
            clk_wait(1);
            waited++;
        end
        total += 2;
        if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL abort_deselect got=busy%b exp=busy0 within 12 clk", busy); end
        if (bus.miso_oe !== 1'b0) begin bad++; $display("[TB] FAIL abort_oe_after got=%b exp=0", bus.miso_oe); end
        clk_wait(3 * HALF);
        addr = 24'($urandom);
        run_read(OP_READ, addr, 2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rx_buf[k] !== mem_byte(addr + 24'(k))) begin bad++; $display("[TB] FAIL abort_reread%0d got=%h exp=%h", k, rx_buf[k], mem_byte(addr + 24'(k))); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] a0, a1;
        logic [7:0]  first0, junk;
        mem_key = 8'($urandom);
        a0 = 24'($urandom);
        a1 = 24'($urandom);
        run_read(OP_READ, a0, 1, 1'b0);
        first0 = rx_buf[0];
        run_read(OP_READ, a1, 3, 1'b0);
        total++;
        if (first0 !== mem_byte(a0)) begin bad++; $display("[TB] FAIL b2b_first got=%h exp=%h", first0, mem_byte(a0)); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rx_buf[k] !== mem_byte(a1 + 24'(k))) begin bad++; $display("[TB] FAIL b2b_second%0d got=%h exp=%h", k, rx_buf[k], mem_byte(a1 + 24'(k))); end
        end
        spi_begin();
        spi_bits(OP_RDID, 8, junk);
        spi_bits(8'h00, 8, rx_buf[0]);
        spi_end();
        total++;
        if (rx_buf[0] !== 8'hEF) begin bad++; $display("[TB] FAIL b2b_rdid got=%h exp=EF", rx_buf[0]); end
    endtask

    task automatic test_fast_read();
        int q0, e0;
        q0 = rd_q.size();
        e0 = cmd_err_cnt;
        mem_key = 8'hA5;
`ifdef SPI_TARGET_FAST_READ_EN
        run_read(OP_FAST_READ, 24'h000020, 2, 1'b1);
        total += 4;
        if (rx_buf[0] !== 8'h85) begin bad++; $display("[TB] FAIL fast_byte0 got=%h exp=85", rx_buf[0]); end
        if (rx_buf[1] !== 8'h84) begin bad++; $display("[TB] FAIL fast_byte1 got=%h exp=84", rx_buf[1]); end
        if (rd_q.size() - q0 !== 3) begin bad++; $display("[TB] FAIL fast_fetch_count got=%0d exp=3", rd_q.size() - q0); end
        else if (rd_q[q0] !== 24'h000020) begin bad++; $display("[TB] FAIL fast_first_addr got=%h exp=000020", rd_q[q0]); end
        total++;
        if (cmd_err_cnt != e0) begin bad++; $display("[TB] FAIL fast_cmd_err got=%0d exp=0", cmd_err_cnt - e0); end
`else
        run_read(OP_FAST_READ, 24'h000020, 2, 1'b1);
        total += 2;
        if (cmd_err_cnt - e0 != 1) begin bad++; $display("[TB] FAIL fast_unsupported_cmd_err got=%0d exp=1", cmd_err_cnt - e0); end
        if (rd_q.size() != q0)     begin bad++; $display("[TB] FAIL fast_unsupported_mem_rd got=%0d exp=0", rd_q.size() - q0); end
`endif
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        n_rst    = 1'b0;
        mem_key  = 8'hA5;
        test_reset();
        test_read_basic();
        test_read_random();
        test_wrap();
        test_rdid();
        test_bad_opcode();
        test_abort();
        test_back_to_back();
        test_fast_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
